// File: rtl/s_mixcolumn_seq.sv
// rtl/s_mixcolumn_seq.sv - column-serial AES MixColumns controller sharing one 32-bit column unit
`timescale 1ns/1ps

module S_mixcolumn_32bit (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  // multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a, b, c, d;
  logic [7:0] a2, b2, c2, d2;

  // one column through the [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] matrix
  always_comb begin
    a  = col_in[31:24];
    b  = col_in[23:16];
    c  = col_in[15:8];
    d  = col_in[7:0];
    a2 = xtime(a);
    b2 = xtime(b);
    c2 = xtime(c);
    d2 = xtime(d);
    col_out[31:24] = a2 ^ (b2 ^ b) ^ c ^ d;
    col_out[23:16] = a ^ b2 ^ (c2 ^ c) ^ d;
    col_out[15:8]  = a ^ b ^ c2 ^ (d2 ^ d);
    col_out[7:0]   = (a2 ^ a) ^ b ^ c ^ d2;
  end

endmodule

module s_mixcolumn_seq #(
  parameter int PIPE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  logic [1:0]   col;
  logic [127:0] st_reg;
  logic         byp_reg;
  logic [127:0] res_reg;

  logic [31:0]  col_in;
  logic [31:0]  col_mix;
  logic [31:0]  col_res;

  logic         wr_en;
  logic [1:0]   wr_idx;
  logic [31:0]  wr_data;

  // select the current column of the captured state for the shared unit
  always_comb begin
    col_in = st_reg[127:96];
    case (col)
      2'd0: col_in = st_reg[127:96];
      2'd1: col_in = st_reg[95:64];
      2'd2: col_in = st_reg[63:32];
      2'd3: col_in = st_reg[31:0];
      default: col_in = st_reg[127:96];
    endcase
  end

  S_mixcolumn_32bit u_col (
    .col_in  (col_in),
    .col_out (col_mix)
  );

  // the unit is always exercised; bypass only chooses what gets stored
  assign col_res = byp_reg ? col_in : col_mix;

  generate
    if (PIPE != 0) begin : g_pipe
      logic [31:0] pipe_reg;

      // register the column result; it lands in the result slot one cycle later
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_reg <= '0;
        end else if (state == RUN) begin
          pipe_reg <= col_res;
        end
      end

      assign wr_en   = ((state == RUN) && (col != 2'd0)) || (state == DRAIN);
      assign wr_idx  = (state == DRAIN) ? 2'd3 : (col - 2'd1);
      assign wr_data = pipe_reg;
    end else begin : g_nopipe
      assign wr_en   = (state == RUN);
      assign wr_idx  = col;
      assign wr_data = col_res;
    end
  endgenerate

  // collect column results into the output state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_reg <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        2'd0: res_reg[127:96] <= wr_data;
        2'd1: res_reg[95:64]  <= wr_data;
        2'd2: res_reg[63:32]  <= wr_data;
        2'd3: res_reg[31:0]   <= wr_data;
        default: res_reg[127:96] <= wr_data;
      endcase
    end
  end

  assign out_data = res_reg;

  // control FSM with registered handshake and busy outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= 2'd0;
      st_reg    <= '0;
      byp_reg   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            st_reg   <= in_data;
            byp_reg  <= in_bypass;
            col      <= 2'd0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          col <= col + 2'd1;
          if (col == 2'd3) begin
            if (PIPE != 0) begin
              state <= DRAIN;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_mixcolumn_seq.sv
// tb/tb_s_mixcolumn_seq.sv - scoreboard bench for s_mixcolumn_seq with PIPE=0 and PIPE=1 instances
`timescale 1ns/1ps

module tb_s_mixcolumn_seq;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] M1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] M2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  typedef struct {
    logic [127:0] data;
    int           acc;
    int           lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0][127:0] in_data;
  logic [1:0]       in_bypass;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][127:0] out_data;
  logic [1:0]       busy;

  exp_t sb [2][$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [1:0] prev = 2'b00;

  s_mixcolumn_seq #(.PIPE(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_bypass(in_bypass[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );

  s_mixcolumn_seq #(.PIPE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_bypass(in_bypass[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // monitor: latency on out_valid rise, data on each output handshake
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (out_valid[k] && !prev[k]) begin
        if (sb[k].size() == 0) begin
          chk($sformatf("spurious_valid%0d", k), {127'b0, out_valid[k]}, 128'd0);
        end else begin
          chk($sformatf("latency%0d", k), 128'(cyc + 1 - sb[k][0].acc), 128'(sb[k][0].lat));
        end
      end
      if (out_valid[k] && out_ready[k] && sb[k].size() != 0) begin
        e = sb[k].pop_front();
        chk($sformatf("out_data%0d", k), out_data[k], e.data);
      end
      prev[k] = out_valid[k];
    end
  end

  task automatic send(input int w, input logic [127:0] d, input logic byp,
                      input logic [127:0] e, output int acc);
    int   n;
    exp_t x;
    n   = 0;
    acc = -1;
    @(negedge clk);
    in_data[w]   = d;
    in_bypass[w] = byp;
    in_valid[w]  = 1'b1;
    while (!in_ready[w] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[w]) begin
      chk($sformatf("accept_timeout%0d", w), {127'b0, in_ready[w]}, 128'd1);
    end else begin
      acc    = cyc + 1;
      x.data = e;
      x.acc  = acc;
      x.lat  = (w == 0) ? 5 : 6;
      sb[w].push_back(x);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(input int w, input int budget);
    int n;
    n = 0;
    while (sb[w].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_timeout%0d", w), 128'(sb[w].size()), 128'd0);
  endtask

  task automatic chk_reset_outputs(input int k);
    chk($sformatf("rst_in_ready%0d", k),  {127'b0, in_ready[k]},  128'd1);
    chk($sformatf("rst_out_valid%0d", k), {127'b0, out_valid[k]}, 128'd0);
    chk($sformatf("rst_busy%0d", k),      {127'b0, busy[k]},      128'd0);
    chk($sformatf("rst_out_data%0d", k),  out_data[k],            128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a, a0, a1, a2, n;
    rst       = 1'b1;
    in_valid  = 2'b00;
    in_bypass = 2'b00;
    in_data   = '0;
    out_ready = 2'b11;

    repeat (2) @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst = 1'b0;

    // known vector on both pipe settings
    send(0, V1, 1'b0, M1, a);
    in_valid[0] = 1'b0;
    wait_empty(0, 20);
    send(1, V1, 1'b0, M1, a);
    in_valid[1] = 1'b0;
    wait_empty(1, 20);

    // bypass then mixed on the same data
    send(0, V2, 1'b1, V2, a);
    in_valid[0] = 1'b0;
    wait_empty(0, 20);
    send(0, V2, 1'b0, M2, a);
    in_valid[0] = 1'b0;
    wait_empty(0, 20);
    send(1, V2, 1'b1, V2, a);
    in_valid[1] = 1'b0;
    wait_empty(1, 20);

    // backpressure: stall in DONE while offering other data
    out_ready[0] = 1'b0;
    send(0, V1, 1'b0, M1, a);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_timeout", {127'b0, out_valid[0]}, 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_data[0]   = V2;
      in_bypass[0] = 1'b1;
      in_valid[0]  = ~in_valid[0];
      chk("bp_out_data",  out_data[0],             M1);
      chk("bp_in_ready",  {127'b0, in_ready[0]},  128'd0);
      chk("bp_out_valid", {127'b0, out_valid[0]}, 128'd1);
      chk("bp_busy",      {127'b0, busy[0]},      128'd1);
    end
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready",  {127'b0, in_ready[0]},  128'd1);
    chk("rel_busy",      {127'b0, busy[0]},      128'd0);
    chk("rel_out_valid", {127'b0, out_valid[0]}, 128'd0);
    chk("rel_out_hold",  out_data[0],            M1);
    wait_empty(0, 5);
    repeat (8) @(negedge clk);

    // back-to-back with in_valid held high
    send(0, V1, 1'b0, M1, a0);
    send(0, V2, 1'b0, M2, a1);
    send(0, V2, 1'b1, V2, a2);
    in_valid[0] = 1'b0;
    chk("b2b_gap1", 128'(a1 - a0), 128'd6);
    chk("b2b_gap2", 128'(a2 - a1), 128'd6);
    wait_empty(0, 20);

    // reset asserted in the second RUN cycle
    send(0, V1, 1'b0, M1, a);
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", {127'b0, busy[0]}, 128'd1);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs(0);
    sb[0].delete();
    @(negedge clk);
    rst = 1'b0;
    send(0, V2, 1'b0, M2, a);
    in_valid[0] = 1'b0;
    wait_empty(0, 20);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s_mixcolumn_seq.md
# s_mixcolumn_seq

Column-serial AES MixColumns controller. It accepts a 128-bit state over a valid/ready handshake and time-multiplexes one shared 32-bit column unit (`S_mixcolumn_32bit`) across the four state columns, one column per cycle. It collects the results and presents the mixed 128-bit state over a second valid/ready handshake. It sits between SubBytes/ShiftRows and AddRoundKey in the iterative round datapath, and replaces the four-instance parallel MixColumns where area matters.

## Interface
- `PIPE`, default 0: 0 means the column unit output is written to the result register in the same cycle; 1 means a register is inserted after the column unit, adding one cycle of latency.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: `in_data` and `in_bypass` are valid.
- `in_ready`, out, 1: block can accept a state.
- `in_data`, in, 128: input state. Column k is bits [127-32k -: 32]; its bytes a,b,c,d run from MSB to LSB.
- `in_bypass`, in, 1: final round; output equals input, with identical timing.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: consumer accepts `out_data`.
- `out_data`, out, 128: mixed state, using the same column/byte mapping as the input.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- Column function uses the standard AES matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8), with polynomial 0x11B.
  - Output byte 0 = 2a^3b^c^d.
  - Output byte 1 = a^2b^3c^d.
  - Output byte 2 = a^b^2c^3d.
  - Output byte 3 = 3a^b^c^2d.
- States: IDLE, RUN, DRAIN (only when PIPE=1), DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: capture `in_data` into `st_reg` and `in_bypass` into `byp_reg`, set `col`=0, go to RUN.
- RUN:
  - Drive column `col` of `st_reg` into the column unit.
  - When `byp_reg`=1, the written value is the unmixed column. The column unit is still driven, so power and timing do not depend on `byp_reg`.
  - PIPE=0: write result slot `col` this cycle.
  - PIPE=1: write result slot `col-1` from the pipe register, skipping the write when `col`=0.
  - `col` increments each cycle (2-bit counter). After `col`=3, go to DONE (PIPE=0) or DRAIN (PIPE=1).
- DRAIN: write slot 3 from the pipe register, then go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_data` is held stable while `out_ready`=0.
  - On `out_ready`=1, go to IDLE.
- `in_ready` is high only in IDLE, so no input is accepted in DONE even when `out_ready` is high.
- `out_data` is driven from the result register at all times. It keeps its last value after a handshake until the next DONE overwrites it. `out_valid` qualifies it.
- `in_valid` is ignored outside IDLE. Input changes after acceptance have no effect because `st_reg` is used.

## Timing
- Reset (async assert):
  - state = IDLE, `col`=0, `st_reg`, result register and pipe register cleared to 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0.
- Reset asserted mid-RUN, DRAIN or DONE aborts the block. No `out_valid` is produced for the aborted state. First acceptance is possible on the first clock edge after deassertion.
- Accept edge = cycle 0.
  - PIPE=0: RUN in cycles 1–4, `out_valid` high from cycle 5.
  - PIPE=1: RUN in cycles 1–4, DRAIN in cycle 5, `out_valid` high from cycle 6.
  - Latency is identical for `in_bypass`=0 and 1.
- Output handshake at edge N (DONE, `out_ready`=1): `in_ready` is high from cycle N+1. Next acceptance is at the earliest at edge N+1.
- Maximum throughput with `out_ready` tied high: one state per 6 cycles (PIPE=0) or 7 cycles (PIPE=1).
- Stalled output: DONE persists indefinitely. `out_data`, `out_valid` and `busy` are constant.
- `busy`=1 from cycle 1 until the cycle after the output handshake.

## Test plan
- Known vector, PIPE=0:
  - In: `in_data`=db135345_f20a225c_01010101_c6c6c6c6, `in_bypass`=0.
  - Required: `out_data`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, `out_valid` rising exactly 5 cycles after acceptance.
- Same vector with PIPE=1: identical `out_data`, `out_valid` after 6 cycles.
- Bypass:
  - In: `in_data`=d4d4d4d5_2d26314c_00000000_ffffffff, `in_bypass`=1.
  - Required: `out_data` equals the input, with the same latency as non-bypass.
  - Then the same data with `in_bypass`=0 requires `out_data`=d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE while pulsing `in_valid` with other data.
  - Required: `out_data` stable, `in_ready`=0, new data not accepted.
  - Release `out_ready`: `in_ready`=1 on the next cycle.
- Back-to-back with `out_ready`=1 and `in_valid` held high over 3 states: acceptances spaced exactly 6 cycles apart (PIPE=0), and each output is correct.
- Reset during RUN (cycle 2):
  - Required: all outputs at reset values immediately (async), with no spurious `out_valid`.
  - A following transaction completes correctly with normal latency.
